// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, func3 encodings,
// the DM command payload and byte-lane shift helpers.
package lsu_mem_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NLANES = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [NLANES-1:0] web;
        logic [XLEN-1:0]   wdata;
    } dm_cmd_t;

    // Byte offset k lives in lane 3-k: shift of 8*(3-k) bits.
    function automatic logic [4:0] byte_shift(input logic [1:0] k);
        return {~k, 3'b000};
    endfunction

    // Halfword at offset k occupies lanes 3-k and 2-k: shift of 8*(2-k) bits.
    function automatic logic [4:0] half_shift(input logic [1:0] k);
        return {2'(2'd2 - k), 3'b000};
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational lane logic: store byte enables and data placement, access legality,
// and extraction plus sign/zero extension of load data.
module lsu_mem_ctrl_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic              is_store,
    input  logic [2:0]        func3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [2:0]        ld_func3,
    input  logic [1:0]        ld_offset,
    input  logic [XLEN-1:0]   rdata,
    output logic [NLANES-1:0] web_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic              misalign_c,
    output logic [XLEN-1:0]   load_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lane placement and legality of the decoded access.
    always_comb begin
        web_c      = '0;
        wdata_c    = '0;
        misalign_c = 1'b0;
        case (func3)
            F3_B: begin
                web_c   = 4'b1000 >> offset;
                wdata_c = {24'd0, rs2_data[7:0]} << byte_shift(offset);
            end
            F3_H: begin
                misalign_c = (offset == 2'd3);
                web_c      = 4'b1100 >> offset;
                wdata_c    = {16'd0, rs2_data[15:0]} << half_shift(offset);
            end
            F3_W: begin
                misalign_c = (offset != 2'd0);
                web_c      = 4'b1111;
                wdata_c    = rs2_data;
            end
            // Unsigned variants exist only for loads.
            F3_BU:   misalign_c = is_store;
            F3_HU:   misalign_c = is_store | (offset == 2'd3);
            default: misalign_c = 1'b1;
        endcase
        if (!is_store) begin
            web_c   = '0;
            wdata_c = '0;
        end
    end

    // Load extraction uses the func3/offset latched at issue.
    always_comb begin
        ld_byte     = 8'(rdata >> byte_shift(ld_offset));
        ld_half     = 16'(rdata >> half_shift(ld_offset));
        load_data_c = '0;
        case (ld_func3)
            F3_B:    load_data_c = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    load_data_c = {{16{ld_half[15]}}, ld_half};
            F3_W:    load_data_c = rdata;
            F3_BU:   load_data_c = {24'd0, ld_byte};
            F3_HU:   load_data_c = {16'd0, ld_half};
            default: load_data_c = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the decoded datapath and data memory: req/ready handshake,
// byte enables, load alignment, pipeline stall and access timeout.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              dm_req,
    input  logic              dm_ready,
    output logic [XLEN-1:0]   dm_addr,
    output logic [NLANES-1:0] dm_web,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic [XLEN-1:0]   dm_rdata,
    output logic              stall,
    output logic [XLEN-1:0]   load_data,
    output logic              load_valid,
    output logic              misalign,
    output logic              timeout_err
);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dm_cmd_t           cmd_q, cmd_d;
    logic [2:0]        ld_func3_q, ld_func3_d;
    logic [1:0]        ld_offset_q, ld_offset_d;
    logic              is_load_q, is_load_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              misalign_q, misalign_d;
    logic              timeout_q, timeout_d;

    logic              req_c;
    logic [NLANES-1:0] web_c;
    logic [XLEN-1:0]   wdata_c;
    logic              misalign_c;
    logic [XLEN-1:0]   ext_c;

    assign req_c = mem_read | mem_write;

    lsu_mem_ctrl_lane_align u_align (
        .is_store    (mem_write),
        .func3       (func3),
        .offset      (addr[1:0]),
        .rs2_data    (rs2_data),
        .ld_func3    (ld_func3_q),
        .ld_offset   (ld_offset_q),
        .rdata       (dm_rdata),
        .web_c       (web_c),
        .wdata_c     (wdata_c),
        .misalign_c  (misalign_c),
        .load_data_c (ext_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        ld_func3_d   = ld_func3_q;
        ld_offset_d  = ld_offset_q;
        is_load_d    = is_load_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        misalign_d   = 1'b0;
        timeout_d    = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    // A simultaneous read and write is handled as a store.
                    is_load_d = ~mem_write;
                    if (misalign_c) begin
                        state_d      = ST_DONE;
                        misalign_d   = 1'b1;
                        load_valid_d = ~mem_write;
                        load_data_d  = '0;
                    end else begin
                        state_d     = ST_ACCESS;
                        cnt_d       = '0;
                        cmd_d.addr  = {addr[XLEN-1:2], 2'b00};
                        cmd_d.web   = web_c;
                        cmd_d.wdata = wdata_c;
                        ld_func3_d  = func3;
                        ld_offset_d = addr[1:0];
                    end
                end
            end
            ST_ACCESS: begin
                if (dm_ready) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    if (is_load_q) begin
                        load_data_d  = ext_c;
                        load_valid_d = 1'b1;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = ST_DONE;
                    cnt_d        = '0;
                    timeout_d    = 1'b1;
                    load_data_d  = '0;
                    load_valid_d = is_load_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // The same instruction is still decoded here; do not re-issue it.
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cmd_q        <= '0;
            ld_func3_q   <= '0;
            ld_offset_q  <= '0;
            is_load_q    <= 1'b0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            ld_func3_q   <= ld_func3_d;
            ld_offset_q  <= ld_offset_d;
            is_load_q    <= is_load_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            misalign_q   <= misalign_d;
            timeout_q    <= timeout_d;
        end
    end

    assign dm_req      = (state_q == ST_ACCESS);
    assign dm_addr     = cmd_q.addr;
    assign dm_web      = cmd_q.web;
    assign dm_wdata    = cmd_q.wdata;
    assign load_data   = load_data_q;
    assign load_valid  = load_valid_q;
    assign misalign    = misalign_q;
    assign timeout_err = timeout_q;

    // Stall must rise in the issue cycle itself so the PC holds; forced low under reset.
    assign stall = rst & ((state_q == ST_ACCESS) | ((state_q == ST_IDLE) & req_c));

endmodule
